// File: rtl/timer_pkg.sv
// Shared types and helpers for the round countdown timer.
//   timer_state_t : controller state encoding
//   bcd_time_t    : packed M:ST:SU time, one BCD digit per field
//   bcd_add_sat() : add a number of seconds to a BCD time, clamped at 9:59
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } timer_state_t;

  localparam int SU_MAX = 9;
  localparam int ST_MAX = 5;
  localparam int M_MAX  = 9;

  typedef struct packed {
    logic [3:0] m;
    logic [3:0] st;
    logic [3:0] su;
  } bcd_time_t;

  // Digit-wise add with carries at 10 (units) and 6 (tens). secs <= 59 keeps
  // every intermediate within a single carry per digit.
  function automatic bcd_time_t bcd_add_sat(input bcd_time_t t, input logic [5:0] secs);
    logic [5:0] add_su;
    logic [5:0] add_st;
    logic [5:0] su_sum;
    logic [5:0] st_sum;
    logic [5:0] m_sum;
    logic       c_su;
    logic       c_st;
    bcd_time_t  r;
    add_su = secs % 6'd10;
    add_st = secs / 6'd10;
    su_sum = {2'b00, t.su} + add_su;
    c_su   = (su_sum >= 6'd10);
    if (c_su) su_sum = su_sum - 6'd10;
    st_sum = {2'b00, t.st} + add_st + {5'b0, c_su};
    c_st   = (st_sum >= 6'd6);
    if (c_st) st_sum = st_sum - 6'd6;
    m_sum  = {2'b00, t.m} + {5'b0, c_st};
    if (m_sum > 6'(M_MAX))
      r = {4'(M_MAX), 4'(ST_MAX), 4'(SU_MAX)};
    else
      r = {m_sum[3:0], st_sum[3:0], su_sum[3:0]};
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit with borrow chaining.
//   clk, reset       : clock, asynchronous active-high reset (digit -> RESET_VAL)
//   load, load_value : synchronous load, wins over counting
//   enable          : count qualifier shared by the whole chain
//   borrow_in       : decrement request from the less significant digit
//   digit           : current value (registered)
//   borrow_out      : this digit is at 0 and is being decremented (wraps to WRAP)
module bcd_digit_down #(
  parameter logic [3:0] WRAP      = 4'd9,
  parameter logic [3:0] RESET_VAL = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_value,
  input  logic       enable,
  input  logic       borrow_in,
  output logic [3:0] digit,
  output logic       borrow_out
);

  assign borrow_out = enable && borrow_in && (digit == 4'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      digit <= RESET_VAL;
    else if (load)
      digit <= load_value;
    else if (enable && borrow_in)
      digit <= (digit == 4'd0) ? WRAP : digit - 4'd1;
  end

endmodule

// File: rtl/game_timer_ctrl.sv
// Round countdown controller: three BCD digits M:ST:SU from preset down to 0:00,
// with its own one-second prescaler, start/pause/reload and bonus-time add.
//   clk, reset      : clock, asynchronous active-high reset
//   load            : reload preset, return to IDLE (highest priority)
//   start           : IDLE -> RUN
//   pause           : toggle RUN <-> PAUSE
//   add_time        : add ADD_SEC seconds, clamped at 9:59 (not in EXPIRED)
//   min_digit, sec_tens, sec_units : registered BCD time
//   running         : high while in RUN
//   time_up         : single-cycle pulse on the first EXPIRED cycle
// Optional build macro TIMER_WARN_EN adds low_time and low_time_blink.
//
// state   | meaning
// IDLE    | preset loaded, prescaler cleared, waiting for start
// RUN     | prescaler counting, digits decrement once per tick
// PAUSE   | prescaler and digits frozen, start ignored
// EXPIRED | digits at 0:00, only load leaves
module game_timer_ctrl
  import timer_pkg::*;
#(
  parameter int TICK_DIV    = 50_000_000,
  parameter int START_MIN   = 3,
  parameter int START_SEC_T = 0,
  parameter int START_SEC_U = 0,
  parameter int ADD_SEC     = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic       add_time,
  output logic [3:0] min_digit,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_units,
  output logic       running,
  output logic       time_up
`ifdef TIMER_WARN_EN
  ,
  output logic       low_time,
  output logic       low_time_blink
`endif
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam bcd_time_t PRESET = {4'(START_MIN), 4'(START_SEC_T), 4'(START_SEC_U)};
  localparam logic [5:0] ADD_P  = 6'(ADD_SEC);
  // Tick and bonus in the same cycle: current - 1 + ADD_SEC == current + (ADD_SEC - 1)
  localparam logic [5:0] ADD_M1 = 6'(ADD_SEC - 1);

  timer_state_t state, state_next;
  logic [PW-1:0] presc;
  bcd_time_t cur, sum_plain, sum_tick, load_val;
  logic tick, add_en, cnt_load, dec_en, cur_zero, result_zero, expire;
  logic b_su, b_st, b_m;
  logic running_next, time_up_next;

  assign cur = {min_digit, sec_tens, sec_units};

  assign tick        = (state == RUN) && (presc == PRESC_LAST);
  assign add_en      = add_time && !load && (state != EXPIRED);
  assign sum_plain   = bcd_add_sat(cur, ADD_P);
  assign sum_tick    = bcd_add_sat(cur, ADD_M1);
  assign cur_zero    = (cur == '0);
  assign dec_en      = tick && !load && !add_en && !cur_zero;
  assign cnt_load    = load || add_en;
  // Expiry looks at the net result, so a bonus landing on a tick can rescue 0:01.
  assign result_zero = add_en ? (sum_tick == '0) : (cur <= 12'h001);
  assign expire      = tick && result_zero;

  always_comb begin
    load_val = sum_plain;
    if (load)
      load_val = PRESET;
    else if (tick)
      load_val = sum_tick;
  end

  bcd_digit_down #(.WRAP(4'(SU_MAX)), .RESET_VAL(4'(START_SEC_U))) u_su (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (load_val.su),
    .enable     (dec_en),
    .borrow_in  (1'b1),
    .digit      (sec_units),
    .borrow_out (b_su)
  );

  bcd_digit_down #(.WRAP(4'(ST_MAX)), .RESET_VAL(4'(START_SEC_T))) u_st (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (load_val.st),
    .enable     (dec_en),
    .borrow_in  (b_su),
    .digit      (sec_tens),
    .borrow_out (b_st)
  );

  bcd_digit_down #(.WRAP(4'(M_MAX)), .RESET_VAL(4'(START_MIN))) u_m (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (load_val.m),
    .enable     (dec_en),
    .borrow_in  (b_st),
    .digit      (min_digit),
    .borrow_out (b_m)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state logic; load beats start beats pause, expiry beats pause
  always_comb begin
    state_next = state;
    if (load) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_next = RUN;
        RUN: begin
          if (expire)     state_next = EXPIRED;
          else if (pause) state_next = PAUSE;
        end
        PAUSE:   if (pause) state_next = RUN;
        EXPIRED: state_next = EXPIRED;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output logic, computed from the next state so the registers line up with state
  always_comb begin
    running_next = (state_next == RUN);
    time_up_next = (state_next == EXPIRED) && (state != EXPIRED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      running <= 1'b0;
      time_up <= 1'b0;
    end else begin
      running <= running_next;
      time_up <= time_up_next;
    end
  end

  // Prescaler: counts only in RUN, frozen in PAUSE so resume keeps the phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (load) begin
      presc <= '0;
    end else begin
      case (state)
        RUN:     presc <= (presc == PRESC_LAST) ? '0 : presc + PW'(1);
        PAUSE:   presc <= presc;
        default: presc <= '0;
      endcase
    end
  end

`ifdef TIMER_WARN_EN
  logic low_next, blink_next;

  // Low-time flag is evaluated on the value the digits will hold next cycle.
  // A plain decrement takes cur to <= 0:10 exactly when cur <= 0:11.
  always_comb begin
    low_next = 1'b0;
    if (!load && (state_next == RUN || state_next == PAUSE)) begin
      if (add_en)
        low_next = (load_val <= 12'h010);
      else if (dec_en)
        low_next = (cur <= 12'h011);
      else
        low_next = (cur <= 12'h010);
    end
    blink_next = 1'b0;
    if (low_next)
      blink_next = tick ? ~low_time_blink : low_time_blink;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      low_time       <= 1'b0;
      low_time_blink <= 1'b0;
    end else begin
      low_time       <= low_next;
      low_time_blink <= blink_next;
    end
  end
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    assert (START_MIN >= 0 && START_MIN <= M_MAX)
      else $error("START_MIN out of digit range");
    assert (START_SEC_T >= 0 && START_SEC_T <= ST_MAX)
      else $error("START_SEC_T out of digit range");
    assert (START_SEC_U >= 0 && START_SEC_U <= SU_MAX)
      else $error("START_SEC_U out of digit range");
    assert (ADD_SEC >= 1 && ADD_SEC <= 59)
      else $error("ADD_SEC out of range");
    assert (!b_m)
      else $error("minutes digit borrowed below 0:00");
    assert (min_digit <= 4'(M_MAX) && sec_tens <= 4'(ST_MAX) && sec_units <= 4'(SU_MAX))
      else $error("illegal BCD digit");
  end
`endif

endmodule

// File: tb/tb_game_timer_ctrl.sv
module tb_game_timer_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic load = 1'b0;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic add_time = 1'b0;
  logic [3:0] min_digit, sec_tens, sec_units;
  logic running, time_up;

  game_timer_ctrl #(
    .TICK_DIV    (4),
    .START_MIN   (0),
    .START_SEC_T (1),
    .START_SEC_U (2),
    .ADD_SEC     (10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .start     (start),
    .pause     (pause),
    .add_time  (add_time),
    .min_digit (min_digit),
    .sec_tens  (sec_tens),
    .sec_units (sec_units),
    .running   (running),
    .time_up   (time_up)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic [11:0] t;
    logic        run;
    logic        tu;
  } ev_t;

  ev_t exp_q[$];
  int total = 0;
  int bad = 0;
  logic [13:0] prev_obs;

  function automatic logic [11:0] to_bcd(input int s);
    int m, t, u;
    m = s / 60;
    t = (s % 60) / 10;
    u = s % 10;
    return {m[3:0], t[3:0], u[3:0]};
  endfunction

  task automatic expect_ev(input int c, input int s, input logic run, input logic tu);
    ev_t e;
    e.c = c;
    e.t = to_bcd(s);
    e.run = run;
    e.tu = tu;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic pulse(input logic l, input logic s, input logic p, input logic a);
    load = l; start = s; pause = p; add_time = a;
    step(1);
    load = 0; start = 0; pause = 0; add_time = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every change of the visible outputs is one event, matched in order
  always @(negedge clk) begin
    logic [13:0] obs;
    ev_t e;
    obs = {min_digit, sec_tens, sec_units, running, time_up};
    if (reset) begin
      prev_obs = obs;
    end else if (obs !== prev_obs) begin
      prev_obs = obs;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event cyc=%0d actual=%h", cyc, obs);
      end else begin
        e = exp_q.pop_front();
        if (cyc != e.c || obs !== {e.t, e.run, e.tu}) begin
          bad++;
          $display("FAIL event actual cyc=%0d val=%h required cyc=%0d val=%h",
                   cyc, obs, e.c, {e.t, e.run, e.tu});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, p, s, r1, r2, q, secs;

    // Reset values
    step(3);
    check("reset_digits", {min_digit, sec_tens, sec_units}, 12'h012);
    check("reset_running", running, 0);
    check("reset_time_up", time_up, 0);
    reset = 0;
    step(1);

    // Countdown 0:12 -> 0:09, four cycles per tick
    c = cyc;
    expect_ev(c + 1, 12, 1, 0);
    expect_ev(c + 5, 11, 1, 0);
    expect_ev(c + 9, 10, 1, 0);
    expect_ev(c + 13, 9, 1, 0);
    pulse(0, 1, 0, 0);

    // Pause after two prescaler cycles, hold 20 cycles, resume
    wait_until(c + 14);
    expect_ev(c + 15, 9, 0, 0);
    pulse(0, 0, 1, 0);
    wait_until(c + 34);
    p = cyc;
    expect_ev(p + 1, 9, 1, 0);
    for (int k = 0; k < 8; k++) expect_ev(p + 3 + 4 * k, 8 - k, 1, 0);
    pulse(0, 0, 1, 0);

    // Tick and bonus together at 0:01 -> 0:10, no expiry
    wait_until(p + 34);
    expect_ev(p + 35, 10, 1, 0);
    pulse(0, 0, 0, 1);
    for (int k = 0; k < 9; k++) expect_ev(p + 39 + 4 * k, 9 - k, 1, 0);
    expect_ev(p + 75, 0, 0, 1);
    expect_ev(p + 76, 0, 0, 0);

    // EXPIRED ignores start, add_time, pause
    wait_until(p + 78);
    pulse(0, 1, 0, 0);
    step(2);
    pulse(0, 0, 0, 1);
    step(2);
    pulse(0, 0, 1, 0);
    step(6);
    check("expired_digits", {min_digit, sec_tens, sec_units}, 12'h000);
    check("expired_running", running, 0);

    // Reload, run down to 0:05, pause
    c = cyc;
    expect_ev(c + 1, 12, 0, 0);
    pulse(1, 0, 0, 0);
    step(1);
    s = cyc;
    expect_ev(s + 1, 12, 1, 0);
    for (int k = 0; k < 7; k++) expect_ev(s + 5 + 4 * k, 11 - k, 1, 0);
    pulse(0, 1, 0, 0);
    wait_until(s + 30);
    expect_ev(s + 31, 5, 0, 0);
    pulse(0, 0, 1, 0);

    // Bonus in PAUSE: 0:05 -> 0:55 -> 1:05 (tens carry into minutes)
    secs = 5;
    for (int k = 0; k < 6; k++) begin
      secs += 10;
      expect_ev(cyc + 1, secs, 0, 0);
      pulse(0, 0, 0, 1);
    end
    check("st_carry_to_min", {min_digit, sec_tens, sec_units}, 12'h105);

    // Resume, count 1:05 -> 0:59 (minute borrow), pause
    r1 = cyc;
    expect_ev(r1 + 1, 65, 1, 0);
    for (int k = 0; k < 6; k++) expect_ev(r1 + 3 + 4 * k, 64 - k, 1, 0);
    pulse(0, 0, 1, 0);
    wait_until(r1 + 24);
    expect_ev(r1 + 25, 59, 0, 0);
    pulse(0, 0, 1, 0);
    check("min_borrow", {min_digit, sec_tens, sec_units}, 12'h059);

    // Bonus up to the 9:59 ceiling, then one more that must not wrap
    while (secs != 599) begin
      if (secs == 65) secs = 59;
      secs = (secs + 10 > 599) ? 599 : secs + 10;
      expect_ev(cyc + 1, secs, 0, 0);
      pulse(0, 0, 0, 1);
    end
    check("reach_959", {min_digit, sec_tens, sec_units}, 12'h959);
    pulse(0, 0, 0, 1);
    step(2);
    check("sat_hold", {min_digit, sec_tens, sec_units}, 12'h959);

    // Resume: 9:58, then tick+bonus saturates back to 9:59
    r2 = cyc;
    expect_ev(r2 + 1, 599, 1, 0);
    expect_ev(r2 + 3, 598, 1, 0);
    pulse(0, 0, 1, 0);
    wait_until(r2 + 6);
    expect_ev(r2 + 7, 599, 1, 0);
    pulse(0, 0, 0, 1);

    // load together with start mid-RUN -> IDLE at preset
    wait_until(r2 + 9);
    expect_ev(r2 + 10, 12, 0, 0);
    pulse(1, 1, 0, 0);
    step(2);
    check("load_start_idle", running, 0);

    // Asynchronous reset mid-RUN
    q = cyc;
    expect_ev(q + 1, 12, 1, 0);
    expect_ev(q + 5, 11, 1, 0);
    pulse(0, 1, 0, 0);
    wait_until(q + 6);
    #1;
    reset = 1;
    #1;
    check("async_rst_digits", {min_digit, sec_tens, sec_units}, 12'h012);
    check("async_rst_running", running, 0);
    check("async_rst_time_up", time_up, 0);
    step(3);
    reset = 0;
    step(6);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_events actual=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
